eth_tx_arbiter: RTL and testbench

- Shares the single MII/GMII TX byte interface between two frame generators: the ARP sender (requester 0) and the UDP sender (requester 1).
- Grants the interface to one requester at a time and muxes that requester's byte stream onto the PHY outputs with one register stage.
- Enforces the inter-frame gap, a start timeout and a maximum frame length.
- Sits in the i_tx_clk domain between the frame generators and the top-level o_tx_data/o_tx_en.

---
 rtl/eth_tx_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_eth_tx_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter
// Shares one MII/GMII TX byte interface between the ARP sender (requester 0)
// and the UDP sender (requester 1). One requester owns the interface at a time;
// its byte stream is forwarded to the PHY through a single register stage.
// The arbiter also enforces an inter-frame gap, a start timeout and a maximum
// frame length.
//
// Optional build macro: ETH_TX_ARB_RR_EN
//   defined   -> round-robin tie break (the requester not served last wins)
//   undefined -> fixed priority, ARP wins a tie
module eth_tx_arbiter #(
    parameter int IFG_BYTES = 12,
    parameter int START_TMO = 64,
    parameter int MAX_FRAME = 1530
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_arp_req,
    output logic        o_arp_gnt,
    input  logic [7:0]  i_arp_tx_data,
    input  logic        i_arp_tx_en,
    input  logic        i_udp_req,
    output logic        o_udp_gnt,
    input  logic [7:0]  i_udp_tx_data,
    input  logic        i_udp_tx_en,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_en,
    output logic        o_busy,
    output logic        o_err_tmo,
    output logic        o_err_long,
    output logic [15:0] o_frame_cnt
);

    localparam int TMO_W = $clog2(START_TMO + 1);
    localparam int LEN_W = $clog2(MAX_FRAME + 2);
    localparam int IFG_W = $clog2(IFG_BYTES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        XMIT  = 2'd2,
        IFG   = 2'd3
    } state_t;

    state_t             state;
    logic [1:0]         gnt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [LEN_W-1:0]   len_cnt;
    logic [IFG_W-1:0]   ifg_cnt;
    logic [7:0]         tx_data_reg;
    logic               tx_en_reg;
    logic               err_tmo_reg;
    logic               err_long_reg;
    logic [15:0]        frame_cnt_reg;

    // Per-requester views, index 0 = ARP, index 1 = UDP
    logic [1:0]         req_vec;
    logic [1:0]         en_vec;
    logic [1:0][7:0]    data_vec;
    logic [1:0]         masked_en;
    logic [1:0][7:0]    masked_data;

    logic               sel_en;
    logic [7:0]         sel_data;
    logic               owner_req;
    logic               tie_pick;
    logic               pick;

    assign req_vec     = {i_udp_req, i_arp_req};
    assign en_vec      = {i_udp_tx_en, i_arp_tx_en};
    assign data_vec[0] = i_arp_tx_data;
    assign data_vec[1] = i_udp_tx_data;

    // Only the granted requester can reach the output mux; the other one is
    // masked to zero so its bytes can never leak onto the PHY.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_mask
            assign masked_en[gi]   = gnt[gi] & en_vec[gi];
            assign masked_data[gi] = gnt[gi] ? data_vec[gi] : 8'h00;
        end
    endgenerate

    assign sel_en    = |masked_en;
    assign sel_data  = masked_data[0] | masked_data[1];
    assign owner_req = |(gnt & req_vec);

`ifdef ETH_TX_ARB_RR_EN
    logic last_served;

    // Remember who completed the last good frame; aborts leave it untouched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_served <= 1'b1;
        end else if (state == XMIT && !sel_en) begin
            last_served <= gnt[1];
        end
    end

    assign tie_pick = ~last_served;
`else
    assign tie_pick = 1'b0;
`endif

    // Winner index when arbitrating in IDLE: single request wins outright
    assign pick = (req_vec == 2'b11) ? tie_pick : req_vec[1];

    // Arbitration FSM with registered grants, PHY outputs and error pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            gnt           <= 2'b00;
            tmo_cnt       <= '0;
            len_cnt       <= '0;
            ifg_cnt       <= '0;
            tx_data_reg   <= 8'h00;
            tx_en_reg     <= 1'b0;
            err_tmo_reg   <= 1'b0;
            err_long_reg  <= 1'b0;
            frame_cnt_reg <= 16'h0000;
        end else begin
            err_tmo_reg  <= 1'b0;
            err_long_reg <= 1'b0;
            case (state)
                IDLE: begin
                    tx_en_reg   <= 1'b0;
                    tx_data_reg <= 8'h00;
                    if (|req_vec) begin
                        gnt     <= pick ? 2'b10 : 2'b01;
                        tmo_cnt <= '0;
                        state   <= GRANT;
                    end
                end
                GRANT: begin
                    if (sel_en) begin
                        // First byte is captured on the transition edge
                        tx_en_reg   <= 1'b1;
                        tx_data_reg <= sel_data;
                        len_cnt     <= LEN_W'(1);
                        state       <= XMIT;
                    end else if (!owner_req) begin
                        // Requester withdrew before starting: quiet release
                        gnt   <= 2'b00;
                        state <= IDLE;
                    end else if (tmo_cnt == TMO_W'(START_TMO - 1)) begin
                        gnt         <= 2'b00;
                        err_tmo_reg <= 1'b1;
                        ifg_cnt     <= '0;
                        state       <= IFG;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                XMIT: begin
                    if (!sel_en) begin
                        tx_en_reg     <= 1'b0;
                        tx_data_reg   <= 8'h00;
                        gnt           <= 2'b00;
                        frame_cnt_reg <= frame_cnt_reg + 16'h0001;
                        ifg_cnt       <= '0;
                        state         <= IFG;
                    end else if (len_cnt == LEN_W'(MAX_FRAME)) begin
                        // One byte beyond the limit: cut the frame here
                        tx_en_reg    <= 1'b0;
                        tx_data_reg  <= 8'h00;
                        gnt          <= 2'b00;
                        err_long_reg <= 1'b1;
                        ifg_cnt      <= '0;
                        state        <= IFG;
                    end else begin
                        tx_en_reg   <= 1'b1;
                        tx_data_reg <= sel_data;
                        len_cnt     <= len_cnt + LEN_W'(1);
                    end
                end
                IFG: begin
                    tx_en_reg   <= 1'b0;
                    tx_data_reg <= 8'h00;
                    if (ifg_cnt == IFG_W'(IFG_BYTES - 1)) begin
                        state <= IDLE;
                    end else begin
                        ifg_cnt <= ifg_cnt + IFG_W'(1);
                    end
                end
                default: begin
                    gnt   <= 2'b00;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign o_arp_gnt   = gnt[0];
    assign o_udp_gnt   = gnt[1];
    assign o_tx_data   = tx_data_reg;
    assign o_tx_en     = tx_en_reg;
    assign o_busy      = (state != IDLE);
    assign o_err_tmo   = err_tmo_reg;
    assign o_err_long  = err_long_reg;
    assign o_frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed testbench for eth_tx_arbiter (default parameters 12/64/1530).
module tb_eth_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        arp_req, arp_tx_en, udp_req, udp_tx_en;
    logic [7:0]  arp_tx_data, udp_tx_data;
    logic        arp_gnt, udp_gnt;
    logic [7:0]  tx_data;
    logic        tx_en, busy, err_tmo, err_long;
    logic [15:0] frame_cnt;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int exp_frames = 0;

    eth_tx_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .i_arp_req     (arp_req),
        .o_arp_gnt     (arp_gnt),
        .i_arp_tx_data (arp_tx_data),
        .i_arp_tx_en   (arp_tx_en),
        .i_udp_req     (udp_req),
        .o_udp_gnt     (udp_gnt),
        .i_udp_tx_data (udp_tx_data),
        .i_udp_tx_en   (udp_tx_en),
        .o_tx_data     (tx_data),
        .o_tx_en       (tx_en),
        .o_busy        (busy),
        .o_err_tmo     (err_tmo),
        .o_err_long    (err_long),
        .o_frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_req(input int who, input logic en, input logic [7:0] d);
        if (who == 0) begin
            arp_tx_en = en; arp_tx_data = d;
        end else begin
            udp_tx_en = en; udp_tx_data = d;
        end
    endtask

    // Polls at the falling edge until the given grant is seen; gcyc=-1 on expiry
    task automatic wait_gnt(input int who, input int limit, output int gcyc);
        gcyc = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if ((who == 0 && arp_gnt) || (who == 1 && udp_gnt)) begin
                gcyc = cyc;
                break;
            end
        end
    endtask

    // Drives nbytes of base+k from requester who and observes the PHY side
    task automatic send_frame(input int who, input int nbytes, input logic [7:0] base,
                              input bit noise, output int en_cycles, output int data_err,
                              output int fall_cyc, output int long_pulses, output int other_gnt);
        logic       prev_en;
        logic [7:0] exp_byte;
        en_cycles = 0; data_err = 0; fall_cyc = -1; long_pulses = 0; other_gnt = 0;
        prev_en = 1'b0;
        for (int i = 0; i < nbytes + 3; i++) begin
            @(posedge clk); #1;
            if (i < nbytes) drive_req(who, 1'b1, base + 8'(i));
            else            drive_req(who, 1'b0, 8'h00);
            if (noise) drive_req(1 - who, i[0], 8'hAA);
            @(negedge clk);
            if (tx_en) begin
                exp_byte = base + 8'(en_cycles);
                if (tx_data !== exp_byte) data_err++;
                en_cycles++;
            end else if (prev_en && fall_cyc < 0) begin
                fall_cyc = cyc;
            end
            prev_en = tx_en;
            if (err_long) begin
                long_pulses++;
                if (who == 0) arp_req = 1'b0; else udp_req = 1'b0;
            end
            if ((who == 0 && udp_gnt) || (who == 1 && arp_gnt)) other_gnt++;
        end
        drive_req(1 - who, 1'b0, 8'h00);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        arp_req = 1'b0; udp_req = 1'b1;
        arp_tx_en = 1'b0; udp_tx_en = 1'b0; arp_tx_data = 8'h00; udp_tx_data = 8'h00;
        repeat (3) @(negedge clk);
        checks++; if ({arp_gnt, udp_gnt} !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b expected 00", {arp_gnt, udp_gnt}); end
        checks++; if ({tx_en, tx_data} !== 9'h000) begin errors++; $display("FAIL reset_tx: got en=%b data=%h expected 0/00", tx_en, tx_data); end
        checks++; if ({busy, err_tmo, err_long} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {busy, err_tmo, err_long}); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
        udp_req = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_udp_frame;
        int c_req, g, g2, en_c, derr, fall, lp, og;
        @(posedge clk); #1;
        udp_req = 1'b1; c_req = cyc;
        wait_gnt(1, 5, g);
        checks++; if (g - c_req !== 1) begin errors++; $display("FAIL udp_gnt_latency: got %0d expected 1", g - c_req); end
        checks++; if ({arp_gnt, busy} !== 2'b01) begin errors++; $display("FAIL udp_gnt_onehot: got arp=%b busy=%b expected 0/1", arp_gnt, busy); end
        send_frame(1, 64, 8'h10, 1'b0, en_c, derr, fall, lp, og);
        exp_frames++;
        checks++; if (en_c !== 64) begin errors++; $display("FAIL udp_len: got %0d expected 64", en_c); end
        checks++; if (derr !== 0) begin errors++; $display("FAIL udp_data: got %0d bad bytes expected 0", derr); end
        checks++; if (udp_gnt !== 1'b0) begin errors++; $display("FAIL udp_gnt_drop: got %b expected 0", udp_gnt); end
        checks++; if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL udp_frame_cnt: got %0d expected %0d", frame_cnt, exp_frames); end
        wait_gnt(1, 30, g2);
        checks++; if (g2 - fall !== 13) begin errors++; $display("FAIL udp_ifg_regrant: got %0d expected 13", g2 - fall); end
        udp_req = 1'b0;
        @(negedge clk);
        checks++; if ({udp_gnt, busy, err_tmo} !== 3'b000) begin errors++; $display("FAIL udp_req_withdraw: got %b expected 000", {udp_gnt, busy, err_tmo}); end
        checks++; if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL udp_withdraw_cnt: got %0d expected %0d", frame_cnt, exp_frames); end
        $display("test_udp_frame done: bytes=%0d frames=%0d", en_c, frame_cnt);
    endtask

    task automatic test_tie;
        int g, g2, en_c, derr, fall, lp, og;
        @(posedge clk); #1;
        arp_req = 1'b1; udp_req = 1'b1;
        wait_gnt(0, 5, g);
        checks++; if (g < 0 || udp_gnt !== 1'b0) begin errors++; $display("FAIL tie_first: got arp_cyc=%0d udp=%b expected ARP only", g, udp_gnt); end
        send_frame(0, 42, 8'h40, 1'b0, en_c, derr, fall, lp, og);
        exp_frames++;
        arp_req = 1'b0;
        checks++; if (en_c !== 42 || derr !== 0) begin errors++; $display("FAIL tie_arp_frame: got len=%0d bad=%0d expected 42/0", en_c, derr); end
        wait_gnt(1, 30, g2);
        checks++; if (g2 - fall !== 13 || arp_gnt !== 1'b0) begin errors++; $display("FAIL tie_second: got gap=%0d arp=%b expected 13/0", g2 - fall, arp_gnt); end
        send_frame(1, 42, 8'h80, 1'b0, en_c, derr, fall, lp, og);
        exp_frames++;
        udp_req = 1'b0;
        checks++; if (en_c !== 42 || derr !== 0) begin errors++; $display("FAIL tie_udp_frame: got len=%0d bad=%0d expected 42/0", en_c, derr); end
        checks++; if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL tie_frame_cnt: got %0d expected %0d", frame_cnt, exp_frames); end
        $display("test_tie done: frames=%0d", frame_cnt);
    endtask

    task automatic test_priority;
        int g, en_c, derr, fall, lp, og, second;
`ifdef ETH_TX_ARB_RR_EN
        second = 1;
`else
        second = 0;
`endif
        arp_req = 1'b1; udp_req = 1'b1;
        wait_gnt(0, 30, g);
        checks++; if (g < 0 || udp_gnt !== 1'b0) begin errors++; $display("FAIL prio_first: got arp_cyc=%0d udp=%b expected ARP", g, udp_gnt); end
        send_frame(0, 20, 8'h01, 1'b0, en_c, derr, fall, lp, og);
        wait_gnt(second, 30, g);
        checks++; if (g < 0 || {udp_gnt, arp_gnt} !== (second == 1 ? 2'b10 : 2'b01)) begin errors++; $display("FAIL prio_second: got udp=%b arp=%b expected requester %0d", udp_gnt, arp_gnt, second); end
        send_frame(second, 20, 8'h21, 1'b0, en_c, derr, fall, lp, og);
        wait_gnt(0, 30, g);
        checks++; if (g < 0 || udp_gnt !== 1'b0) begin errors++; $display("FAIL prio_third: got arp_cyc=%0d udp=%b expected ARP", g, udp_gnt); end
        send_frame(0, 20, 8'h41, 1'b0, en_c, derr, fall, lp, og);
        arp_req = 1'b0; udp_req = 1'b0;
        exp_frames += 3;
        checks++; if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL prio_frame_cnt: got %0d expected %0d", frame_cnt, exp_frames); end
        $display("test_priority done: second winner=%0d frames=%0d", second, frame_cnt);
    endtask

    task automatic test_timeout;
        int g, pulses, pulse_cyc, regrant, en_seen;
        bit gnt_at_pulse;
        pulses = 0; pulse_cyc = -1; regrant = -1; en_seen = 0; gnt_at_pulse = 1'b0;
        udp_req = 1'b1;
        wait_gnt(1, 30, g);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_en) en_seen++;
            if (err_tmo) begin
                pulses++; pulse_cyc = cyc;
                if (udp_gnt) gnt_at_pulse = 1'b1;
            end else if (pulses > 0 && udp_gnt) begin
                regrant = cyc;
                break;
            end
        end
        udp_req = 1'b0;
        checks++; if (pulses !== 1) begin errors++; $display("FAIL tmo_pulses: got %0d expected 1", pulses); end
        checks++; if (pulse_cyc - g !== 64) begin errors++; $display("FAIL tmo_delay: got %0d expected 64", pulse_cyc - g); end
        checks++; if (gnt_at_pulse !== 1'b0 || en_seen !== 0) begin errors++; $display("FAIL tmo_gnt_clear: got gnt=%b en_cycles=%0d expected 0/0", gnt_at_pulse, en_seen); end
        checks++; if (regrant - pulse_cyc !== 13) begin errors++; $display("FAIL tmo_ifg: got %0d expected 13", regrant - pulse_cyc); end
        checks++; if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL tmo_frame_cnt: got %0d expected %0d", frame_cnt, exp_frames); end
        @(negedge clk);
        $display("test_timeout done: pulse after %0d cycles", pulse_cyc - g);
    endtask

    task automatic test_overrun;
        int g, en_c, derr, fall, lp, og;
        arp_req = 1'b1;
        wait_gnt(0, 30, g);
        send_frame(0, 1600, 8'h00, 1'b0, en_c, derr, fall, lp, og);
        arp_req = 1'b0;
        checks++; if (en_c !== 1530) begin errors++; $display("FAIL long_len: got %0d expected 1530", en_c); end
        checks++; if (derr !== 0) begin errors++; $display("FAIL long_data: got %0d bad bytes expected 0", derr); end
        checks++; if (lp !== 1) begin errors++; $display("FAIL long_pulses: got %0d expected 1", lp); end
        checks++; if (arp_gnt !== 1'b0) begin errors++; $display("FAIL long_gnt: got %b expected 0", arp_gnt); end
        checks++; if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL long_frame_cnt: got %0d expected %0d", frame_cnt, exp_frames); end
        $display("test_overrun done: bytes=%0d", en_c);
    endtask

    task automatic test_isolation;
        int g, en_c, derr, fall, lp, og;
        udp_req = 1'b1;
        wait_gnt(1, 30, g);
        send_frame(1, 30, 8'h00, 1'b1, en_c, derr, fall, lp, og);
        udp_req = 1'b0;
        exp_frames++;
        checks++; if (en_c !== 30 || derr !== 0) begin errors++; $display("FAIL iso_data: got len=%0d bad=%0d expected 30/0", en_c, derr); end
        checks++; if (og !== 0) begin errors++; $display("FAIL iso_arp_gnt: got %0d cycles expected 0", og); end
        checks++; if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL iso_frame_cnt: got %0d expected %0d", frame_cnt, exp_frames); end
        $display("test_isolation done: bytes=%0d", en_c);
    endtask

    task automatic test_async_reset;
        int g, c_req, en_c, derr, fall, lp, og, seen;
        seen = 0;
        udp_req = 1'b1;
        wait_gnt(1, 30, g);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            drive_req(1, 1'b1, 8'h30 + 8'(i));
            @(negedge clk);
            if (tx_en) seen++;
            if (seen == 20) break;
        end
        rst = 1'b1;
        #1;
        checks++; if ({tx_en, udp_gnt, arp_gnt, busy} !== 4'b0000) begin errors++; $display("FAIL arst_outputs: got en=%b gnt=%b%b busy=%b expected 0", tx_en, udp_gnt, arp_gnt, busy); end
        checks++; if (frame_cnt !== 16'd0 || tx_data !== 8'h00) begin errors++; $display("FAIL arst_cnt: got cnt=%0d data=%h expected 0/00", frame_cnt, tx_data); end
        drive_req(1, 1'b0, 8'h00);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; c_req = cyc;
        exp_frames = 0;
        wait_gnt(1, 5, g);
        checks++; if (g - c_req !== 1) begin errors++; $display("FAIL arst_regrant: got %0d expected 1", g - c_req); end
        send_frame(1, 8, 8'hC0, 1'b0, en_c, derr, fall, lp, og);
        udp_req = 1'b0;
        exp_frames++;
        checks++; if (en_c !== 8 || derr !== 0 || frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL arst_frame: got len=%0d bad=%0d cnt=%0d expected 8/0/%0d", en_c, derr, frame_cnt, exp_frames); end
        $display("test_async_reset done: bytes before reset=%0d", seen);
    endtask

    initial begin
        test_reset();
        test_udp_frame();
        test_tie();
        test_priority();
        test_timeout();
        test_overrun();
        test_isolation();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
